ahb_decoder: RTL and testbench

Address-phase decoder and data-phase select generator for the system bus, sitting between the master and the three slaves. It decodes the master's address into one-hot slave selects and registers the select into the data phase. The registered select is presented as `SEL` to `Read_MUX`, and the slaves' ready signals are combined into the global `HREADY`. Unmapped accesses are served by an internal default slave that issues the two-cycle AHB ERROR response.

---
 rtl/bus_pkg.sv | 39 +++
 rtl/ahb_default_slave.sv | 80 ++++++++
 rtl/ahb_decoder.sv | 105 ++++++++++
 tb/tb_ahb_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared encodings for the system-bus decoder:
//   - HTRANS transfer types
//   - SEL data-phase select codes presented to Read_MUX
//   - address region codes taken from the top two HADDR bits
//   - default-slave FSM states
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    SEL_S1  = 2'b00,
    SEL_S2  = 2'b01,
    SEL_S3  = 2'b10,
    SEL_DEF = 2'b11
  } sel_t;

  localparam logic [1:0] REGION_S1       = 2'b00;
  localparam logic [1:0] REGION_S2       = 2'b01;
  localparam logic [1:0] REGION_S3       = 2'b10;
  localparam logic [1:0] REGION_UNMAPPED = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that carry real work.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// -----------------------------------------------------------------------------
// ahb_default_slave
// Serves unmapped accesses with the two-cycle AHB ERROR response, and
// optionally counts how many error responses were started.
// Optional feature macro: AHB_DECODER_ERR_CNT_EN (error counter present).
// Ports:
//   clk, rst    bus clock, asynchronous active-high reset
//   hready      global HREADY (address phase accepted when 1)
//   unmapped    current address phase targets the unmapped region
//   htrans      current transfer type
//   ready       default-slave HREADYOUT
//   resp        default-slave HRESP (1 = ERROR)
//   err_count   saturating count of error responses (0 when disabled)
// -----------------------------------------------------------------------------
module ahb_default_slave
  import bus_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hready,
  input  logic             unmapped,
  input  logic [1:0]       htrans,
  output logic             ready,
  output logic             resp,
  output logic [CNT_W-1:0] err_count
);

  ds_state_t state_q;
  ds_state_t state_d;
  logic      err_req;

  // An error starts only for an accepted unmapped NONSEQ/SEQ; IDLE/BUSY
  // to the unmapped region get a zero-wait OKAY.
  assign err_req = hready && unmapped && is_active(htrans);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    resp    = 1'b0;
    unique case (state_q)
      DS_IDLE: begin
        if (err_req) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ready   = 1'b0;
        resp    = 1'b1;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        resp    = 1'b1;
        state_d = err_req ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

`ifdef AHB_DECODER_ERR_CNT_EN
  logic err_start;

  assign err_start = (state_d == DS_ERR1) && (state_q != DS_ERR1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_start && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: rtl/ahb_decoder.sv
// -----------------------------------------------------------------------------
// ahb_decoder
// Address-phase decoder and data-phase select generator for a three-slave
// AHB bus. Decodes HADDR[ADDR_W-1:ADDR_W-2] into one-hot HSEL_x, registers the
// select into the data phase (SEL, to Read_MUX), and muxes the selected
// slave's ready into the global HREADY. The unmapped region is served by an
// internal default slave that returns the two-cycle ERROR response.
// Optional feature macro: AHB_DECODER_ERR_CNT_EN (ERR_COUNT active; else 0).
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   HADDR, HTRANS, HWRITE      master address phase
//   HREADYOUT_1..3             per-slave ready
//   HSEL_1..3                  combinational one-hot address-phase select
//   SEL                        registered data-phase select (11 = default)
//   HREADY, HRESP              global ready and response
//   ERR_COUNT                  saturating count of unmapped error responses
// -----------------------------------------------------------------------------
module ahb_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADYOUT_1,
  input  logic              HREADYOUT_2,
  input  logic              HREADYOUT_3,
  output logic              HSEL_1,
  output logic              HSEL_2,
  output logic              HSEL_3,
  output logic [1:0]        SEL,
  output logic              HREADY,
  output logic              HRESP,
  output logic [CNT_W-1:0]  ERR_COUNT
);

  logic [1:0] region;
  sel_t       addr_sel;
  sel_t       sel_q;
  logic       unmapped;
  logic       ds_ready;
  logic       ds_resp;
  logic       unused;

  // Direction does not affect decoding; low address bits are slave-local.
  assign unused = ^{HWRITE, HADDR[ADDR_W-3:0]};

  assign region   = HADDR[ADDR_W-1:ADDR_W-2];
  assign unmapped = (region == REGION_UNMAPPED);

  // Address-phase decode: zero latency, independent of HTRANS.
  always_comb begin
    HSEL_1   = 1'b0;
    HSEL_2   = 1'b0;
    HSEL_3   = 1'b0;
    addr_sel = SEL_DEF;
    unique case (region)
      REGION_S1: begin HSEL_1 = 1'b1; addr_sel = SEL_S1; end
      REGION_S2: begin HSEL_2 = 1'b1; addr_sel = SEL_S2; end
      REGION_S3: begin HSEL_3 = 1'b1; addr_sel = SEL_S3; end
      default:   addr_sel = SEL_DEF;
    endcase
  end

  // Address phase -> data phase boundary: SEL advances only when the
  // current data phase completes, so a wait state stalls the pending select.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         sel_q <= SEL_S1;
    else if (HREADY) sel_q <= addr_sel;
  end

  assign SEL = sel_q;

  always_comb begin
    HREADY = HREADYOUT_1;
    unique case (sel_q)
      SEL_S1:  HREADY = HREADYOUT_1;
      SEL_S2:  HREADY = HREADYOUT_2;
      SEL_S3:  HREADY = HREADYOUT_3;
      SEL_DEF: HREADY = ds_ready;
      default: HREADY = HREADYOUT_1;
    endcase
  end

  // Only the default slave ever answers ERROR; mapped slaves are OKAY here.
  assign HRESP = (sel_q == SEL_DEF) && ds_resp;

  ahb_default_slave #(
    .CNT_W(CNT_W)
  ) u_default_slave (
    .clk       (CLK),
    .rst       (RST),
    .hready    (HREADY),
    .unmapped  (unmapped),
    .htrans    (HTRANS),
    .ready     (ds_ready),
    .resp      (ds_resp),
    .err_count (ERR_COUNT)
  );

endmodule

// File: tb/tb_ahb_decoder.sv
module tb_ahb_decoder;

  localparam logic [31:0] A1 = 32'h0000_0010;
  localparam logic [31:0] A2 = 32'h4000_0010;
  localparam logic [31:0] A3 = 32'h8000_0010;
  localparam logic [31:0] AU = 32'hC000_0000;
  localparam logic [1:0]  ID = 2'b00;
  localparam logic [1:0]  NS = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = A1;
  logic [1:0]  htrans = ID;
  logic        hwrite = 1'b0;
  logic        rdy1 = 1'b1, rdy2 = 1'b1, rdy3 = 1'b1;
  logic        hsel1, hsel2, hsel3;
  logic [1:0]  sel;
  logic        hready, hresp;
  logic [3:0]  err_count;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [2:0] hsel;
    logic [1:0] sel;
    logic       hready;
    logic       hresp;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  ahb_decoder #(.ADDR_W(32), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADYOUT_1(rdy1), .HREADYOUT_2(rdy2), .HREADYOUT_3(rdy3),
    .HSEL_1(hsel1), .HSEL_2(hsel2), .HSEL_3(hsel3), .SEL(sel),
    .HREADY(hready), .HRESP(hresp), .ERR_COUNT(err_count)
  );

  always #5 clk = ~clk;

  // Expected counter value after n error responses since reset.
  function automatic logic [3:0] cnt_of(input int n);
`ifdef AHB_DECODER_ERR_CNT_EN
    return (n > 15) ? 4'hF : 4'(n);
`else
    return 4'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue what
  // the outputs must show during that cycle.
  task automatic step(input logic [31:0] a, input logic [1:0] t,
                      input logic [2:0] rdy, input logic r,
                      input logic [2:0] hs, input logic [1:0] s,
                      input logic hr, input logic rp, input int n);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    haddr  = a;
    htrans = t;
    rdy1   = rdy[0];
    rdy2   = rdy[1];
    rdy3   = rdy[2];
    hwrite = ~hwrite;
    e.hsel = hs; e.sel = s; e.hready = hr; e.hresp = rp; e.cnt = cnt_of(n);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hsel",      {5'd0, hsel3, hsel2, hsel1}, {5'd0, e.hsel});
      chk("sel",       {6'd0, sel},                 {6'd0, e.sel});
      chk("hready",    {7'd0, hready},              {7'd0, e.hready});
      chk("hresp",     {7'd0, hresp},               {7'd0, e.hresp});
      chk("err_count", {4'd0, err_count},           {4'd0, e.cnt});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, %0d checks done", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n = 0;
    // Reset holds SEL=00, so HREADY follows HREADYOUT_1 (driven low here).
    step(A1, ID, 3'b110, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, n);
    // Mapped transfers to slaves 1, 2, 3; SEL lags one cycle.
    step(A1, NS, 3'b111, 1'b0, 3'b001, 2'b00, 1'b1, 1'b0, n);
    step(A2, NS, 3'b111, 1'b0, 3'b010, 2'b00, 1'b1, 1'b0, n);
    step(A3, NS, 3'b111, 1'b0, 3'b100, 2'b01, 1'b1, 1'b0, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b10, 1'b1, 1'b0, n);
    // Slave 2 inserts 3 wait states while the next address targets slave 3.
    step(A2, NS, 3'b111, 1'b0, 3'b010, 2'b00, 1'b1, 1'b0, n);
    step(A3, NS, 3'b101, 1'b0, 3'b100, 2'b01, 1'b0, 1'b0, n);
    step(A3, NS, 3'b101, 1'b0, 3'b100, 2'b01, 1'b0, 1'b0, n);
    step(A3, NS, 3'b101, 1'b0, 3'b100, 2'b01, 1'b0, 1'b0, n);
    step(A3, NS, 3'b111, 1'b0, 3'b100, 2'b01, 1'b1, 1'b0, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b10, 1'b1, 1'b0, n);
    // SEL=00: an unselected slave's low ready must not leak into HREADY.
    step(A1, ID, 3'b011, 1'b0, 3'b001, 2'b00, 1'b1, 1'b0, n);
    // Unmapped NONSEQ: ERROR with wait, ERROR ready, then OKAY.
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, n);
    n = 1;
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b11, 1'b0, 1'b1, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b11, 1'b1, 1'b1, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b00, 1'b1, 1'b0, n);
    // Unmapped IDLE: zero-wait OKAY from the default slave, no count.
    step(AU, ID, 3'b111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b11, 1'b1, 1'b0, n);
    // Back-to-back unmapped NONSEQs, then a mapped NONSEQ after ERR2.
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, n);
    n = 2;
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b11, 1'b0, 1'b1, n);
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b11, 1'b1, 1'b1, n);
    n = 3;
    step(A2, NS, 3'b111, 1'b0, 3'b010, 2'b11, 1'b0, 1'b1, n);
    step(A2, NS, 3'b111, 1'b0, 3'b010, 2'b11, 1'b1, 1'b1, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b01, 1'b1, 1'b0, n);
    // Asynchronous reset in the middle of DS_ERR1.
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, n);
    n = 0;
    step(A1, ID, 3'b111, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, n);
    // After release, the error restarts from DS_ERR1.
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, n);
    n = 1;
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b11, 1'b0, 1'b1, n);
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b11, 1'b1, 1'b1, n);
    // 17 unmapped NONSEQs back to back: counter saturates, never wraps.
    step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, n);
    n++;
    for (int k = 0; k < 17; k++) begin
      step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b11, 1'b0, 1'b1, n);
      if (k < 16) begin
        step(AU, NS, 3'b111, 1'b0, 3'b000, 2'b11, 1'b1, 1'b1, n);
        n++;
      end else begin
        step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b11, 1'b1, 1'b1, n);
      end
    end
    step(A1, ID, 3'b111, 1'b0, 3'b001, 2'b00, 1'b1, 1'b0, n);
    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
